// File: rtl/uart_pkg.sv
// Shared UART transmitter types and constants.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the transmitter state enum.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , PARITY
`endif
    } uart_tx_state_t;

    localparam int STOP_BITS_ONE = 1;
    localparam int STOP_BITS_TWO = 2;

    localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = !clr && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a synchronous FIFO and serialises them LSB first.
// Define FIFO_UART_TX_PARITY_EN to send a parity bit between the data and stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 2 || CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        (STOP_BITS != STOP_BITS_ONE && STOP_BITS != STOP_BITS_TWO)) begin : g_bad_params
        $error("fifo_uart_tx: illegal parameter combination");
    end

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  baud_clr;
    logic                  bit_end;
    logic                  last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (baud_clr),
        .bit_end(bit_end)
    );

    assign last_stop = (STOP_BITS == STOP_BITS_ONE) || stop_cnt_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        baud_clr   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_clr = 1'b1;
                if (tx_en && !fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                baud_clr = 1'b1;
                state_d  = LOAD;
            end
            LOAD: begin
                baud_clr   = 1'b1;
                shift_d    = fifo_data;
                idx_d      = '0;
                stop_cnt_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                // Shift register is consumed during DATA, so parity is taken at capture.
                par_d      = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
                state_d    = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed from the next state so the tx flop changes with the state.
        tx_d = UART_IDLE;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = UART_IDLE;
        endcase

        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE;
            done_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign fifo_rd_en = (state_q == REQ);
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues expected frames, a line monitor decodes and checks them.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int NB  = 1 + DW + PB + SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_en = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Simple FIFO model: registered read data one cycle after the pop.
    logic [DW-1:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int rd_err = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                rd_err <= rd_err + 1;
            end else begin
                fifo_data <= mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        bit            abort;
        int            gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   frames_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic p, input bit ab, input int gap);
        exp_t e;
        e.data = d;
        e.par = p;
        e.abort = ab;
        e.gap = gap;
        sb.push_back(e);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000 && frames_done < target; i++) @(posedge clk);
        check("frames_seen", frames_done, target);
    endtask

    task automatic wait_tx_low();
        for (int i = 0; i < 300 && tx !== 1'b0; i++) @(negedge clk);
        check("start_bit_seen", int'(tx), 0);
    endtask

    // Line monitor: decodes each frame cycle by cycle against the next scoreboard entry.
    initial begin : monitor
        int   idle_cnt;
        int   bad;
        int   gap;
        bit   aborted;
        exp_t e;
        logic bits [0:NB-1];
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                idle_cnt = 0;
                continue;
            end
            if (tx === 1'b1) begin
                idle_cnt++;
                if (tx_done !== 1'b0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_tx_done: got %b, required 0", tx_done);
                end
                continue;
            end
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_frame: tx low with empty scoreboard");
                for (int i = 0; i < 100 && tx !== 1'b1; i++) @(negedge clk);
                idle_cnt = 0;
                continue;
            end
            e = sb.pop_front();
            gap = idle_cnt;
            bits[0] = 1'b0;
            for (int i = 0; i < DW; i++) bits[1 + i] = e.data[i];
            if (PB == 1) bits[1 + DW] = e.par;
            for (int s = 0; s < SB; s++) bits[1 + DW + PB + s] = 1'b1;
            bad = 0;
            aborted = 1'b0;
            for (int b = 0; b < NB && !aborted; b++) begin
                for (int c = 0; c < CPB && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (!rst) aborted = 1'b1;
                    else if (tx !== bits[b] || busy !== 1'b1) bad++;
                end
            end
            @(negedge clk);
            n_vec++;
            if (aborted) begin
                if (!e.abort || bad != 0 || tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_%02h: errors=%0d tx=%b busy=%b tx_done=%b, required abort with 0 errors tx=1 busy=0 tx_done=0",
                             e.data, bad, tx, busy, tx_done);
                end
            end else if (e.abort || bad != 0 || tx !== 1'b1 || tx_done !== 1'b1 || busy !== 1'b0 ||
                         (e.gap >= 0 && gap != e.gap)) begin
                n_fail++;
                $display("FAIL frame_%02h: bit_errors=%0d tx_done=%b busy=%b gap=%0d, required 0 errors tx_done=1 busy=0 gap=%0d completed=%0d",
                         e.data, bad, tx_done, busy, gap, e.gap, !e.abort);
            end
            idle_cnt = aborted ? 0 : 1;
            frames_done++;
        end
    end

    initial begin : stimulus
        int rc;
        int viol;
        int rd_lat;
        int tx_lat;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_rd_en", int'(fifo_rd_en), 0);
        check("reset_tx_done", int'(tx_done), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single word 0xA5 (even parity 0)
        push_word(8'hA5, 1'b0, 1'b0, -1);
        tx_en = 1'b1;
        wait_frames(1);

        // Three queued words, back to back
        @(posedge clk); #1;
        tx_en = 1'b0;
        rc = rd_cnt;
        push_word(8'h00, 1'b0, 1'b0, -1);
        push_word(8'hFF, 1'b0, 1'b0, 3);
        push_word(8'h3C, 1'b0, 1'b0, 3);
        @(posedge clk); #1;
        tx_en = 1'b1;
        wait_frames(4);
        check("burst_rd_pulses", rd_cnt - rc, 3);

        // Empty FIFO for 100 cycles
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("empty_idle_violations", viol, 0);

        // tx_en dropped during DATA of 0x55; 0x12 must wait
        @(posedge clk); #1;
        rc = rd_cnt;
        push_word(8'h55, 1'b0, 1'b0, -1);
        push_word(8'h12, 1'b0, 1'b0, -1);
        wait_tx_low();
        repeat (10) @(posedge clk);
        #1;
        tx_en = 1'b0;
        wait_frames(5);
        repeat (50) @(posedge clk);
        check("paused_rd_pulses", rd_cnt - rc, 1);
        check("paused_fifo_empty", int'(fifo_empty), 0);
        #1;
        tx_en = 1'b1;
        rd_lat = -1;
        tx_lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rd_lat < 0 && fifo_rd_en === 1'b1) rd_lat = k;
            if (tx_lat < 0 && tx === 1'b0) tx_lat = k;
        end
        check("resume_rd_en_cycle", rd_lat, 2);
        check("resume_tx_fall_cycle", tx_lat, 4);
        wait_frames(6);

        // Reset asserted during DATA of 0x99
        @(posedge clk); #1;
        push_word(8'h99, 1'b0, 1'b1, -1);
        wait_tx_low();
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_frames(7);

        // Normal traffic after reset: 0x6B (odd popcount) then 0x81 back to back
        @(posedge clk); #1;
        push_word(8'h6B, 1'b1, 1'b0, -1);
        push_word(8'h81, 1'b0, 1'b0, 3);
        wait_frames(9);

        repeat (5) @(posedge clk);
        check("pop_while_empty", rd_err, 0);
        check("total_rd_pulses", rd_cnt, 9);
        check("scoreboard_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains the team's synchronous FIFO. It sits directly downstream of the FIFO read port. It pops one word whenever the FIFO is non-empty and transmission is enabled, then serialises that word onto `tx` as an asynchronous frame: start bit, data LSB-first, optional parity, stop bit(s). It also owns the FIFO read handshake; `fifo_rd_en` is never asserted while `fifo_empty` is high.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of a FIFO word and of the UART data field.
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit; must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset; synchronous, active-low; clock `clk`.
- `tx_en` in 1: permits the start of new frames.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in `DATA_WIDTH`: FIFO registered read data.
- `fifo_rd_en` out 1: FIFO pop request.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high from leaving IDLE until the last stop bit completes.
- `tx_done` out 1: one-cycle pulse marking frame completion.

## Operation
- States: IDLE, REQ, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE → REQ when `tx_en` and `!fifo_empty`; otherwise stay in IDLE.
- REQ: `fifo_rd_en` = 1 for exactly this cycle, decoded from the state register. The FIFO presents the word on the following cycle.
- LOAD: capture `fifo_data` into the shift register and clear the counters, then go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles.
- DATA: `DATA_WIDTH` bits, LSB first, each held for `CLKS_PER_BIT` cycles. The bit index counter is `$clog2(DATA_WIDTH)` bits wide.
- PARITY: `tx` = XOR of the captured word, XOR `PARITY_ODD`.
- STOP: `tx` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter is `$clog2(CLKS_PER_BIT)` bits wide and counts 0..`CLKS_PER_BIT`−1. The bit ends when it reaches `CLKS_PER_BIT`−1.
- `tx_done` pulses in the first IDLE cycle after STOP; this output is registered.
- `busy` = (state ≠ IDLE).
- `tx_en` falling mid-frame: the current frame completes; no new REQ is issued.
- `fifo_empty` cannot rise between REQ and LOAD, because this block is the only reader. No recheck is done.
- Reset mid-frame: the frame is aborted and the captured word is lost. `tx` is high at the next edge. The FIFO is reset by its own logic.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_rd_en` = 0, `tx_done` = 0; state IDLE; all counters and the shift register at 0.
- Latency: `!fifo_empty` sampled in IDLE at cycle N → `fifo_rd_en` in N+1 → capture in N+2 → `tx` falls at N+3.
- Frame length: (1 + `DATA_WIDTH` + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P = 1 with parity compiled in and 0 without.
- Back-to-back frames: 3 idle-high cycles (IDLE, REQ, LOAD) between the last stop bit and the next start bit.
- `tx` is driven straight from a flop, so it is glitch-free.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined: the PARITY state exists and one parity bit is sent between DATA and STOP.
- Undefined: there is no PARITY state or parity logic; DATA goes directly to STOP. `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - the legal `STOP_BITS` constants;
  - the idle-line constant `UART_IDLE` = 1'b1.
- One sub-module, `uart_baud_cnt`: parameterised by `CLKS_PER_BIT`, with a clear input and a `bit_end` pulse output.

## Test plan
- `CLKS_PER_BIT`=4, FIFO holds 0xA5, parity on, even → `tx` = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit held 4 cycles. `tx_done` pulses once.
- FIFO pre-loaded with 0x00, 0xFF, 0x3C, `tx_en`=1 → exactly 3 `fifo_rd_en` pulses, 3 frames, each gap 3 cycles; `busy` drops after the third frame.
- `fifo_empty`=1 for 100 cycles → `fifo_rd_en` stays 0, `tx` stays 1, `busy` stays 0.
- `tx_en` dropped during DATA of 0x55 → that frame completes correctly; no further REQ while `tx_en`=0; resumes within 1 cycle after `tx_en` returns to 1.
- `rst`=0 asserted mid-DATA → next edge: `tx`=1, `busy`=0, `tx_done`=0; after release, the next word transmits normally.
- `STOP_BITS`=2, macro undefined, 0x81 → frame of 11 bits × `CLKS_PER_BIT`, with no parity bit.
